// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers (IF/ID, ID/EX, EX/MEM).
// Holds the default bundle field widths, the NOP encoding and the occupancy codes.
package pipe_pkg;

    localparam int PC_SIZE_DEFAULT   = 32;
    localparam int INST_SIZE_DEFAULT = 32;
    localparam int LANES_DEFAULT     = 2;
    localparam int CNT_SIZE_DEFAULT  = 16;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // True when the stage can still take a bundle without overwriting the skid entry.
    function automatic logic occ_has_room(input occ_t occ);
        return occ != OCC_FULL;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter shared by the elastic stage registers.
// Updates on the falling edge, like the pipeline registers it sits beside.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH = CNT_SIZE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(negedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/if_id_elastic.sv
// IF/ID stage register with valid/ready handshake and a 2-entry skid buffer.
// o_ready comes from registered occupancy only, so decode back-pressure never reaches fetch combinationally.
module if_id_elastic
    import pipe_pkg::*;
#(
    parameter int                   PC_SIZE   = PC_SIZE_DEFAULT,
    parameter int                   INST_SIZE = INST_SIZE_DEFAULT,
    parameter int                   LANES     = LANES_DEFAULT,
    parameter logic [INST_SIZE-1:0] NOP_INSTR = INST_SIZE'(NOP_INSTR_DEFAULT),
    parameter int                   CNT_SIZE  = CNT_SIZE_DEFAULT
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_pipe_en,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [LANES*INST_SIZE-1:0] i_instr,
    input  logic [LANES-1:0]           i_lane_valid,
    input  logic [PC_SIZE-1:0]         i_next_pc,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [LANES*INST_SIZE-1:0] o_instr,
    output logic [LANES-1:0]           o_lane_valid,
    output logic [PC_SIZE-1:0]         o_next_pc,
    output logic [1:0]                 o_occupancy,
    output logic [CNT_SIZE-1:0]        o_bubble_cnt
);

    occ_t occ_reg;
    occ_t occ_next;

    logic [LANES*INST_SIZE-1:0] main_instr_reg;
    logic [LANES-1:0]           main_lv_reg;
    logic [PC_SIZE-1:0]         main_pc_reg;
    logic [LANES*INST_SIZE-1:0] skid_instr_reg;
    logic [LANES-1:0]           skid_lv_reg;
    logic [PC_SIZE-1:0]         skid_pc_reg;

    logic push;
    logic pop;
    logic active_flush;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic bubble_inc;

    assign push         = i_valid & o_ready;
    assign pop          = o_valid & i_ready & i_pipe_en;
    assign active_flush = i_pipe_en & i_flush;

    // Occupancy state register
    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            occ_reg <= OCC_EMPTY;
        end else begin
            occ_reg <= occ_next;
        end
    end

    // Next occupancy and entry load strobes; flush beats push/pop, freeze beats everything.
    always_comb begin
        occ_next       = occ_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_pipe_en) begin
            if (i_flush) begin
                occ_next = OCC_EMPTY;
            end else begin
                case (occ_reg)
                    OCC_EMPTY: begin
                        if (push) begin
                            occ_next     = OCC_ONE;
                            load_main_in = 1'b1;
                        end
                    end
                    OCC_ONE: begin
                        if (push && pop) begin
                            load_main_in = 1'b1;
                        end else if (push) begin
                            occ_next  = OCC_FULL;
                            load_skid = 1'b1;
                        end else if (pop) begin
                            occ_next = OCC_EMPTY;
                        end
                    end
                    OCC_FULL: begin
                        if (pop) begin
                            occ_next       = OCC_ONE;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: begin
                        occ_next = OCC_EMPTY;
                    end
                endcase
            end
        end
    end

    // Output decode from registered state
    always_comb begin
        o_valid      = (occ_reg != OCC_EMPTY);
        o_ready      = i_pipe_en & occ_has_room(occ_reg);
        o_lane_valid = o_valid ? main_lv_reg : '0;
        o_next_pc    = main_pc_reg;
        o_occupancy  = occ_reg;
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_out
            assign o_instr[gi*INST_SIZE +: INST_SIZE] =
                o_lane_valid[gi] ? main_instr_reg[gi*INST_SIZE +: INST_SIZE] : NOP_INSTR;
        end
    endgenerate

    // A flushed push still hands its next-PC to decode so the redirect target is visible.
    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            main_instr_reg <= {LANES{NOP_INSTR}};
            main_lv_reg    <= '0;
            main_pc_reg    <= '0;
            skid_instr_reg <= {LANES{NOP_INSTR}};
            skid_lv_reg    <= '0;
            skid_pc_reg    <= '0;
        end else begin
            if (load_main_in) begin
                main_instr_reg <= i_instr;
                main_lv_reg    <= i_lane_valid;
                main_pc_reg    <= i_next_pc;
            end else if (load_main_skid) begin
                main_instr_reg <= skid_instr_reg;
                main_lv_reg    <= skid_lv_reg;
                main_pc_reg    <= skid_pc_reg;
            end else if (active_flush) begin
                main_lv_reg <= '0;
                if (push) begin
                    main_pc_reg <= i_next_pc;
                end
            end
            if (load_skid) begin
                skid_instr_reg <= i_instr;
                skid_lv_reg    <= i_lane_valid;
                skid_pc_reg    <= i_next_pc;
            end
        end
    end

    assign bubble_inc = ~o_valid | i_flush;

    pipe_sat_counter #(
        .WIDTH (CNT_SIZE)
    ) u_bubble_cnt (
        .clk   (i_clock),
        .reset (i_reset),
        .en    (i_pipe_en),
        .inc   (bubble_inc),
        .count (o_bubble_cnt)
    );

endmodule
